sync_fifo_prog: RTL and testbench

Parametrised single-clock FIFO, successor to the team's basic synchronous FIFO. Adds:
- selectable standard or first-word-fall-through (FWFT) read mode
- run-time programmable almost-full/almost-empty thresholds
- occupancy output and synchronous flush
- sticky overflow/underflow error flags

Used as the general buffering element between streaming blocks in the datapath.

---
 rtl/sync_fifo_prog.sv | 144 ++++++++++++++
 tb/tb_sync_fifo_prog.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with standard or first-word-fall-through read,
// programmable almost-full/almost-empty, occupancy, flush and sticky errors.
module sync_fifo_prog #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter bit FWFT  = 1'b0,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             I_CLK,
    input  logic             I_RESETN,
    input  logic             I_WE,
    input  logic [WIDTH-1:0] I_DIN,
    input  logic             I_RE,
    input  logic             I_FLUSH,
    input  logic             I_CLR_ERR,
    input  logic [CW-1:0]    I_AFULL_TH,
    input  logic [CW-1:0]    I_AEMPTY_TH,
    output logic [WIDTH-1:0] O_DOUT,
    output logic             O_VALID,
    output logic [CW-1:0]    O_COUNT,
    output logic             O_FULL,
    output logic             O_EMPTY,
    output logic             O_AFULL,
    output logic             O_AEMPTY,
    output logic             O_OVERFLOW,
    output logic             O_UNDERFLOW
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEP_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             ovf_q;
    logic             udf_q;

    logic [CW-1:0]    mem_cnt;
    logic             full;
    logic             empty;
    logic             rd_ok;
    logic             wr_ok;
    logic             pop_mem;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Accept decisions; in FWFT the presented word is counted but no longer in the array
    always_comb begin
        full    = (count == DEP_C);
        empty   = FWFT ? !valid_q : (count == '0);
        rd_ok   = I_RE && !empty;
        wr_ok   = I_WE && (!full || rd_ok);
        mem_cnt = FWFT ? (count - CW'(valid_q)) : count;
        if (FWFT) begin
            pop_mem = (!valid_q || rd_ok) && (mem_cnt != '0);
        end else begin
            pop_mem = rd_ok;
        end
    end

    // Storage array, deliberately without reset
    always_ff @(posedge I_CLK) begin
        if (wr_ok && !I_FLUSH) begin
            mem[wr_ptr] <= I_DIN;
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear
    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (I_WE && !wr_ok && !I_FLUSH) begin
                ovf_q <= 1'b1;
            end else if (I_CLR_ERR) begin
                ovf_q <= 1'b0;
            end
            if (I_RE && !rd_ok && !I_FLUSH) begin
                udf_q <= 1'b1;
            end else if (I_CLR_ERR) begin
                udf_q <= 1'b0;
            end
        end
    end

    // Pointers, occupancy and read-data register; flush overrides traffic
    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else if (I_FLUSH) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= nxt(wr_ptr);
            end
            if (pop_mem) begin
                rd_ptr <= nxt(rd_ptr);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
            if (FWFT) begin
                if (pop_mem) begin
                    dout_q  <= mem[rd_ptr];
                    valid_q <= 1'b1;
                end else if (rd_ok) begin
                    valid_q <= 1'b0;
                end
            end else begin
                valid_q <= rd_ok;
                if (rd_ok) begin
                    dout_q <= mem[rd_ptr];
                end
            end
        end
    end

    assign O_DOUT      = dout_q;
    assign O_VALID     = valid_q;
    assign O_COUNT     = count;
    assign O_FULL      = full;
    assign O_EMPTY     = empty;
    assign O_AFULL     = (count >= I_AFULL_TH);
    assign O_AEMPTY    = (count <= I_AEMPTY_TH);
    assign O_OVERFLOW  = ovf_q;
    assign O_UNDERFLOW = udf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: standard DEPTH=16 and FWFT DEPTH=10 instances
// share traffic; a queue model plus scoreboard checks both.
module tb_sync_fifo_prog;

    localparam int DEP [2] = '{16, 10};
    localparam bit FW  [2] = '{1'b0, 1'b1};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       we    = 1'b0;
    logic       re    = 1'b0;
    logic       flush = 1'b0;
    logic       clr   = 1'b0;
    logic [7:0] din   = 8'h00;
    logic [4:0] af0   = 5'd16;
    logic [4:0] ae0   = 5'd0;
    logic [3:0] af1   = 4'd10;
    logic [3:0] ae1   = 4'd0;

    logic [7:0] dout0, dout1;
    logic [4:0] cnt0;
    logic [3:0] cnt1;
    logic       val0, full0, emp0, afl0, aem0, ovf0, udf0;
    logic       val1, full1, emp1, afl1, aem1, ovf1, udf1;

    int total = 0;
    int bad   = 0;

    byte unsigned mq [2][$];
    byte unsigned sb [2][$];
    bit shown [2];
    bit sv    [2];
    bit movf  [2];
    bit mudf  [2];

    always #5 clk = ~clk;

    sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(1'b0)) u0 (
        .I_CLK(clk), .I_RESETN(rst_n), .I_WE(we), .I_DIN(din),
        .I_RE(re), .I_FLUSH(flush), .I_CLR_ERR(clr),
        .I_AFULL_TH(af0), .I_AEMPTY_TH(ae0),
        .O_DOUT(dout0), .O_VALID(val0), .O_COUNT(cnt0),
        .O_FULL(full0), .O_EMPTY(emp0), .O_AFULL(afl0),
        .O_AEMPTY(aem0), .O_OVERFLOW(ovf0), .O_UNDERFLOW(udf0)
    );

    sync_fifo_prog #(.WIDTH(8), .DEPTH(10), .FWFT(1'b1)) u1 (
        .I_CLK(clk), .I_RESETN(rst_n), .I_WE(we), .I_DIN(din),
        .I_RE(re), .I_FLUSH(flush), .I_CLR_ERR(clr),
        .I_AFULL_TH(af1), .I_AEMPTY_TH(ae1),
        .O_DOUT(dout1), .O_VALID(val1), .O_COUNT(cnt1),
        .O_FULL(full1), .O_EMPTY(emp1), .O_AFULL(afl1),
        .O_AEMPTY(aem1), .O_OVERFLOW(ovf1), .O_UNDERFLOW(udf1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a word queue; FWFT presents the head once it was
    // stored before an edge and not popped at that edge.
    task automatic model_step(input int i);
        int sz;
        int left;
        bit emp;
        bit ful;
        bit rok;
        bit wok;
        byte unsigned w;
        sz  = mq[i].size();
        emp = FW[i] ? !shown[i] : (sz == 0);
        ful = (sz == DEP[i]);
        rok = re && !emp;
        wok = we && (!ful || rok);
        if (we && !wok && !flush) movf[i] = 1'b1;
        else if (clr) movf[i] = 1'b0;
        if (re && !rok && !flush) mudf[i] = 1'b1;
        else if (clr) mudf[i] = 1'b0;
        if (flush) begin
            mq[i].delete();
            sb[i].delete();
            shown[i] = 1'b0;
            sv[i] = 1'b0;
        end else begin
            left = sz - int'(rok);
            if (rok) begin
                w = mq[i].pop_front();
                if (!FW[i]) sb[i].push_back(w);
            end
            if (wok) begin
                mq[i].push_back(din);
                if (FW[i]) sb[i].push_back(din);
            end
            sv[i] = rok && !FW[i];
            shown[i] = FW[i] && (left > 0);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                sb[i].delete();
                shown[i] = 1'b0;
                sv[i] = 1'b0;
                movf[i] = 1'b0;
                mudf[i] = 1'b0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic check_inst(
        input int i, input int dout, input int vld, input int cnt,
        input int ful, input int emp, input int afl, input int aem,
        input int ovf, input int udf, input int af, input int ae
    );
        int sz;
        int ev;
        string p;
        sz = mq[i].size();
        ev = FW[i] ? int'(shown[i]) : int'(sv[i]);
        p  = $sformatf("u%0d.", i);
        chk({p, "count"}, cnt, sz);
        chk({p, "valid"}, vld, ev);
        chk({p, "full"}, ful, int'(sz == DEP[i]));
        chk({p, "empty"}, emp, FW[i] ? int'(!shown[i]) : int'(sz == 0));
        chk({p, "afull"}, afl, int'(sz >= af));
        chk({p, "aempty"}, aem, int'(sz <= ae));
        chk({p, "ovf"}, ovf, int'(movf[i]));
        chk({p, "udf"}, udf, int'(mudf[i]));
        if (vld != 0 && (!FW[i] || re)) begin
            if (sb[i].size() == 0) begin
                chk({p, "sb_nodata"}, 1, 0);
            end else begin
                chk({p, "dout"}, dout, int'(sb[i].pop_front()));
            end
        end
    endtask

    always @(negedge clk) begin
        check_inst(0, dout0, val0, cnt0, full0, emp0, afl0, aem0,
                   ovf0, udf0, af0, ae0);
        check_inst(1, dout1, val1, cnt1, full1, emp1, afl1, aem1,
                   ovf1, udf1, af1, ae1);
    end

    task automatic step(input bit w, input byte unsigned d,
                        input bit r, input bit f = 1'b0,
                        input bit c = 1'b0);
        we = w;
        din = d;
        re = r;
        flush = f;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pw;
        int pr;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.empty0", emp0, 1);
        chk("rst.empty1", emp1, 1);
        chk("rst.dout1", dout1, 0);
        rst_n = 1'b1;
        step(0, 0, 0);

        for (int k = 1; k <= 16; k++) step(1, 8'(k), 0);
        step(1, 8'hAA, 0);
        chk("fill.count0", cnt0, 16);
        chk("fill.full0", full0, 1);
        chk("fill.ovf0", ovf0, 1);
        chk("fill.count1", cnt1, 10);
        for (int k = 0; k < 16; k++) step(0, 0, 1);
        step(0, 0, 0);
        chk("drain.count0", cnt0, 0);
        chk("drain.empty0", emp0, 1);

        step(0, 0, 0, 0, 1);
        chk("clr.ovf0", ovf0, 0);
        step(0, 0, 1);
        chk("udf.set0", udf0, 1);
        chk("udf.count0", cnt0, 0);
        step(0, 0, 0, 0, 1);
        chk("udf.clr0", udf0, 0);
        step(0, 0, 1);
        step(0, 0, 1, 0, 1);
        chk("udf.setwins0", udf0, 1);
        step(0, 0, 0, 0, 1);

        step(1, 8'h5A, 0);
        chk("fwft.lat1", val1, 0);
        step(0, 0, 0);
        chk("fwft.valid1", val1, 1);
        chk("fwft.dout1", dout1, 8'h5A);
        step(0, 0, 1);
        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'h33, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 1);
        chk("fwft.gone1", val1, 0);
        step(0, 0, 0, 0, 1);

        for (int k = 0; k < 5; k++) step(1, 8'($urandom), 0);
        for (int k = 0; k < 35; k++) step(1, 8'($urandom), 1);
        chk("stream.count0", cnt0, 5);
        for (int k = 0; k < 20; k++) step(1, 8'($urandom), 0);
        step(0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(1, 8'($urandom), 1);
        chk("fullrw.count0", cnt0, 16);
        chk("fullrw.count1", cnt1, 10);
        chk("fullrw.ovf1", ovf1, 0);
        for (int k = 0; k < 20; k++) step(0, 0, 1);
        step(0, 0, 0, 0, 1);

        af0 = 5'd12; ae0 = 5'd3;
        af1 = 4'd12; ae1 = 4'd3;
        for (int k = 0; k < 10; k++) step(1, 8'($urandom), 0);
        chk("th.afull_pre0", afl0, 0);
        af0 = 5'd8;
        #1;
        chk("th.afull_now0", afl0, 1);
        for (int k = 0; k < 4; k++) step(1, 8'($urandom), 0);

        step(0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        for (int k = 0; k < 7; k++) step(1, 8'($urandom), 0);
        step(1, 8'hEE, 0, 1);
        chk("flush.count0", cnt0, 0);
        chk("flush.empty0", emp0, 1);
        chk("flush.ovf0", ovf0, 0);
        chk("flush.valid1", val1, 0);

        for (int s = 0; s < 16; s++) begin
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            af0 = 5'($urandom_range(0, 31));
            ae0 = 5'($urandom_range(0, 31));
            af1 = 4'($urandom_range(0, 15));
            ae1 = 4'($urandom_range(0, 15));
            for (int k = 0; k < 50; k++) begin
                step($urandom_range(0, 99) < pw, 8'($urandom),
                     $urandom_range(0, 99) < pr,
                     $urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < 4);
            end
        end

        for (int k = 0; k < 12; k++) step(1, 8'($urandom), k[0]);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.count0", cnt0, 0);
        chk("arst.count1", cnt1, 0);
        chk("arst.valid1", val1, 0);
        chk("arst.dout1", dout1, 0);
        chk("arst.empty0", emp0, 1);
        chk("arst.full0", full0, 0);
        chk("arst.ovf0", ovf0, 0);
        chk("arst.udf1", udf1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step($urandom_range(0, 1) == 1, 8'($urandom),
                 $urandom_range(0, 1) == 1);
        end
        step(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
